instr_issue_seq: RTL and testbench
==================================

Name: instr_issue_seq

Overview:
Upstream instruction source for the mipscpu core. It feeds the core's instrword/newinstr inputs.
- Holds a small loadable program store.
- On start, walks the store from address 0. Each word is presented on instrword, followed by a one-cycle newinstr strobe.
- After each strobe it waits a fixed gap so the multicycle core can finish before the next word is issued.
- Stops on a halt sentinel or at the end of the store.

Parameters:
DEPTH, 16, number of 32-bit instruction slots (power of two)
ADDR_W, 4, log2(DEPTH)
GAP_CYCLES, 16, idle cycles after each newinstr strobe before the next issue; legal range >= 1
HALT_WORD, 32'hFFFF_FFFF, sentinel word that ends the program; never issued

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clock
load_en  in  1  write load_data into store at load_addr (honoured only in IDLE/DONE)
load_addr  in  ADDR_W  store write address
load_data  in  32  store write data
start  in  1  begin issuing from address 0 (honoured only in IDLE/DONE)
instrword  out  32  instruction presented to core; registered; held between issues
newinstr  out  1  one-cycle issue strobe to core
busy  out  1  high in SETUP/PULSE/WAIT
done  out  1  high in DONE
pc  out  ADDR_W  address of the word currently or last issued
issued_count  out  ADDR_W+1  number of strobes since last start

Behaviour:
- Reset values: instrword=0, newinstr=0, busy=0, done=0, pc=0, issued_count=0, state=IDLE. Reset does NOT clear the store.
- Reset asserted mid-operation: at the next edge newinstr=0 and state=IDLE. No partial strobe occurs.
- States and transitions:
  - IDLE: start → SETUP, with pc=0 and issued_count=0.
  - SETUP: read store[pc].
    - If word==HALT_WORD → DONE; instrword unchanged, no strobe.
    - Else instrword<=word → PULSE.
  - PULSE: newinstr=1 for exactly this cycle; issued_count+=1.
    - If pc==DEPTH-1 → DONE.
    - Else pc+=1, gap counter loaded with GAP_CYCLES-1 → WAIT.
  - WAIT: counter decrements each cycle; at 0 → SETUP.
  - DONE: done=1; start → SETUP, with pc=0 and issued_count=0.
- Timing:
  - start sampled at edge N. instrword is valid after edge N+1 and newinstr is high after edge N+2.
  - instrword is stable at least one full cycle before and during newinstr.
  - Strobe-to-strobe period = GAP_CYCLES+2 cycles.
- pc never wraps. After slot DEPTH-1 is issued the block goes to DONE. pc then holds DEPTH-1.
- load_en while busy is ignored, so the store is unchanged.
- start while busy is ignored.
- load_en and start in the same IDLE/DONE cycle: the write commits at that edge, and SETUP reads one cycle later. A new word at address 0 is therefore the one issued (write-first).
- Store: synchronous write, asynchronous read. No reset of contents.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SETUP, PULSE, WAIT, DONE);
  - the HALT_WORD default;
  - MIPS field constants (opcode LW=6'd35, SW=6'd43, R-type=0) for benches building words as {op,rs,rt,imm}.
- One sub-module: instr_store. It is a DEPTH x 32 register array with sync write and async read, instantiated once.
- The FSM, gap counter and output registers live in instr_issue_seq.

Test Plan:
- Program: lw $1,0($0)=32'h8C01_0000; lw $2,1($0)=32'h8C02_0001; lw $3,2($0)=32'h8C03_0002; HALT at slot 3. Apply start → exactly 3 newinstr pulses spaced 18 cycles apart (GAP=16), instrword matching each word during its pulse, then done=1, issued_count=3, pc=2.
- Store HALT_WORD at slot 0, then start → no newinstr pulse; done=1 two cycles after start; instrword keeps its prior value.
- Fill all 16 slots with non-halt words, then start → 16 pulses, done=1 after the last; pc=15, no wrap; issued_count=16.
- Assert reset during WAIT after the 2nd pulse → next edge: newinstr=0, busy=0, pc=0, issued_count=0. Re-start → store intact, slot 0 word reissued first.
- While busy, pulse start and load_en (addr 1, data 32'h0) → pulse count and order unchanged; slot 1 keeps its original word.
- In IDLE, same cycle: load_en addr 0, data 32'h8C05_0000, plus start → first pulse carries 32'h8C05_0000.

Source files
------------

// File: rtl/instr_issue_seq_pkg.sv
// Shared types and constants for the instruction issue sequencer and its benches.
package instr_issue_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // MIPS opcode field values used when assembling I-type words
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  function automatic logic [31:0] mk_itype(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_store.sv
// DEPTH x 32 program store: synchronous write, asynchronous read, contents not reset.
module instr_store #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_seq.sv
// Walks the program store from slot 0, presenting each word then a one-cycle
// newinstr strobe, with a fixed idle gap so the multicycle core can retire it.
module instr_issue_seq
  import instr_issue_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  output logic [31:0]       instrword,
  output logic              newinstr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   issued_count
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [GAP_W-1:0]  gap_cnt;
  logic [31:0]       rd_word_c;
  logic              idle_c;

  assign idle_c = (state == S_IDLE) || (state == S_DONE);

  instr_store #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clock (clock),
    .we    (load_en && idle_c),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_word_c)
  );

  // rd_addr is the next slot to fetch; pc tracks the slot most recently issued
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      instrword    <= '0;
      newinstr     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pc           <= '0;
      rd_addr      <= '0;
      issued_count <= '0;
      gap_cnt      <= '0;
    end else begin
      newinstr <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_SETUP;
            rd_addr      <= '0;
            pc           <= '0;
            issued_count <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        S_SETUP: begin
          if (rd_word_c == HALT_WORD) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            instrword <= rd_word_c;
            pc        <= rd_addr;
            state     <= S_PULSE;
          end
        end
        S_PULSE: begin
          newinstr     <= 1'b1;
          issued_count <= issued_count + (ADDR_W + 1)'(1);
          if (rd_addr == LAST_ADDR) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (gap_cnt == '0) state <= S_SETUP;
          else               gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_seq.sv
// Directed bench for instr_issue_seq: table-driven programs plus corner-case sequences.
module tb_instr_issue_seq;
  import instr_issue_seq_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned GAP    = 16;
  localparam int          PERIOD = GAP + 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic [31:0]       instrword;
  logic              newinstr;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   issued_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] pw_q [$];
  int          pc_q [$];
  logic [31:0] prev_word = '0;
  logic [31:0] last_word;
  logic [31:0] rw [4];

  typedef struct {
    int nwords;
    int exp_pulses;
    int exp_pc;
    int exp_count;
  } vec_t;

  vec_t vecs [5];

  instr_issue_seq #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .GAP_CYCLES (GAP),
    .HALT_WORD  (HALT_WORD_DEFAULT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .instrword    (instrword),
    .newinstr     (newinstr),
    .busy         (busy),
    .done         (done),
    .pc           (pc),
    .issued_count (issued_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every strobe: word must have been stable the previous cycle; log word and cycle
  always @(negedge clock) begin
    if (newinstr === 1'b1) begin
      chk("instrword_stable_before_strobe", 64'(instrword), 64'(prev_word));
      pw_q.push_back(instrword);
      pc_q.push_back(cyc);
    end
    prev_word = instrword;
  end

  function automatic logic [31:0] word_of(input int i);
    return mk_itype(OP_LW, 5'd0, 5'(i + 1), 16'(i));
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = ADDR_W'(addr);
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    pw_q.delete();
    pc_q.delete();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_done_timeout", 64'(done), 64'(1));
  endtask

  task automatic wait_pulses(input int count, input int budget);
    int n = 0;
    while (pw_q.size() < count && n < budget) begin
      tick();
      n++;
    end
    chk("wait_pulses_timeout", 64'(pw_q.size() >= count), 64'(1));
  endtask

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    start     = 1'b0;
    load_addr = '0;
    load_data = '0;
    last_word = '0;
    tick();
    tick();
    chk("rst_instrword", 64'(instrword), 64'(0));
    chk("rst_newinstr", 64'(newinstr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pc", 64'(pc), 64'(0));
    chk("rst_issued_count", 64'(issued_count), 64'(0));
    reset = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // {words before halt, pulses, final pc, final issued_count}
    vecs[0] = '{nwords: 3,  exp_pulses: 3,  exp_pc: 2,  exp_count: 3};
    vecs[1] = '{nwords: 0,  exp_pulses: 0,  exp_pc: 0,  exp_count: 0};
    vecs[2] = '{nwords: 16, exp_pulses: 16, exp_pc: 15, exp_count: 16};
    vecs[3] = '{nwords: 1,  exp_pulses: 1,  exp_pc: 0,  exp_count: 1};
    vecs[4] = '{nwords: 15, exp_pulses: 15, exp_pc: 14, exp_count: 15};

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].nwords; j++) load(j, word_of(j));
      if (vecs[v].nwords < int'(DEPTH)) load(vecs[v].nwords, HALT_WORD_DEFAULT);
      clear_log();
      start_prog();
      chk("busy_after_start", 64'(busy), 64'(1));
      tick();
      chk("done_at_n1", 64'(done), 64'(vecs[v].nwords == 0));
      chk("newinstr_low_at_n1", 64'(newinstr), 64'(0));
      chk("instrword_at_n1", 64'(instrword),
          64'((vecs[v].nwords == 0) ? last_word : word_of(0)));
      tick();
      chk("newinstr_at_n2", 64'(newinstr), 64'(vecs[v].nwords > 0));
      wait_done(2000);
      tick();
      chk("pulse_count", 64'(pw_q.size()), 64'(vecs[v].exp_pulses));
      for (int i = 0; i < pw_q.size(); i++) begin
        chk("pulse_word", 64'(pw_q[i]), 64'(word_of(i)));
        if (i > 0) chk("pulse_spacing", 64'(pc_q[i] - pc_q[i-1]), 64'(PERIOD));
      end
      chk("final_pc", 64'(pc), 64'(vecs[v].exp_pc));
      chk("final_issued_count", 64'(issued_count), 64'(vecs[v].exp_count));
      chk("final_busy", 64'(busy), 64'(0));
      chk("final_done", 64'(done), 64'(1));
      if (vecs[v].nwords > 0) last_word = word_of(vecs[v].nwords - 1);
      chk("final_instrword", 64'(instrword), 64'(last_word));
    end

    // Reset in WAIT after the second strobe, then re-run from an intact store
    for (int k = 0; k < 4; k++) begin
      rw[k] = mk_itype(OP_SW, 5'd0, 5'(k + 1), 16'(k + 8));
      load(k, rw[k]);
    end
    load(4, HALT_WORD_DEFAULT);
    clear_log();
    start_prog();
    wait_pulses(2, 200);
    tick();
    tick();
    tick();
    chk("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    chk("midrst_newinstr", 64'(newinstr), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_pc", 64'(pc), 64'(0));
    chk("midrst_issued_count", 64'(issued_count), 64'(0));
    reset = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("midrst_no_more_pulses", 64'(pw_q.size()), 64'(2));
    clear_log();
    start_prog();
    wait_done(2000);
    tick();
    chk("restart_pulse_count", 64'(pw_q.size()), 64'(4));
    if (pw_q.size() > 0) chk("restart_first_word", 64'(pw_q[0]), 64'(rw[0]));
    chk("restart_issued_count", 64'(issued_count), 64'(4));

    // start and load_en while busy must be ignored
    for (int j = 0; j < 3; j++) load(j, word_of(j));
    load(3, HALT_WORD_DEFAULT);
    clear_log();
    start_prog();
    wait_pulses(1, 200);
    load_en   = 1'b1;
    load_addr = ADDR_W'(1);
    load_data = 32'h0;
    start     = 1'b1;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    wait_done(2000);
    tick();
    chk("busy_ign_pulse_count", 64'(pw_q.size()), 64'(3));
    for (int i = 0; i < pw_q.size(); i++) chk("busy_ign_word", 64'(pw_q[i]), 64'(word_of(i)));
    chk("busy_ign_issued_count", 64'(issued_count), 64'(3));
    clear_log();
    start_prog();
    wait_done(2000);
    tick();
    chk("slot1_intact_count", 64'(pw_q.size()), 64'(3));
    if (pw_q.size() > 1) chk("slot1_intact_word", 64'(pw_q[1]), 64'(word_of(1)));

    // Same-cycle load to slot 0 and start: new word is issued first
    clear_log();
    load_en   = 1'b1;
    load_addr = '0;
    load_data = 32'h8C05_0000;
    start     = 1'b1;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    tick();
    chk("wf_instrword_n1", 64'(instrword), 64'(32'h8C05_0000));
    wait_done(2000);
    tick();
    chk("wf_pulse_count", 64'(pw_q.size()), 64'(3));
    if (pw_q.size() > 0) chk("wf_first_word", 64'(pw_q[0]), 64'(32'h8C05_0000));
    chk("wf_pc", 64'(pc), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
